// File: rtl/branch_pred_if.sv
// ---------------------------------------------------------------------------
// branch_pred_if
//   Bundles the fetch lookup port, the resolved-branch update port and the
//   registered prediction outputs of branch_pred_unit.
//
//   Handshake: every *_VALID_SI strobe is a single-cycle, valid-only
//   qualifier. There is no ready signal because the predictor accepts a
//   lookup and an update every cycle. PRED_VALID_SP is LKP_VALID_SI delayed by
//   exactly one clock, and the other PRED_* fields are zero whenever
//   PRED_VALID_SP is zero.
//
//   master : fetch/decode side (drives lookup, update and flush)
//   slave  : predictor side   (drives the PRED_* outputs)
// ---------------------------------------------------------------------------
interface branch_pred_if #(
    parameter int ADR_W = 32
);
    logic             LKP_VALID_SI;
    logic [ADR_W-1:0] LKP_ADR_SI;

    logic             PRED_VALID_SP;
    logic             PRED_TAKEN_SP;
    logic [ADR_W-1:0] PRED_ADR_SP;
    logic             PRED_RAS_SP;

    logic             UPD_VALID_SI;
    logic [ADR_W-1:0] UPD_ADR_SI;
    logic [ADR_W-1:0] UPD_TARGET_SI;
    logic             UPD_TAKEN_SI;
    logic             UPD_CALL_SI;
    logic             UPD_RET_SI;
    logic [ADR_W-1:0] UPD_RET_ADR_SI;

    logic             FLUSH_SI;

    modport master (
        output LKP_VALID_SI, LKP_ADR_SI,
        output UPD_VALID_SI, UPD_ADR_SI, UPD_TARGET_SI, UPD_TAKEN_SI,
        output UPD_CALL_SI, UPD_RET_SI, UPD_RET_ADR_SI, FLUSH_SI,
        input  PRED_VALID_SP, PRED_TAKEN_SP, PRED_ADR_SP, PRED_RAS_SP
    );

    modport slave (
        input  LKP_VALID_SI, LKP_ADR_SI,
        input  UPD_VALID_SI, UPD_ADR_SI, UPD_TARGET_SI, UPD_TAKEN_SI,
        input  UPD_CALL_SI, UPD_RET_SI, UPD_RET_ADR_SI, FLUSH_SI,
        output PRED_VALID_SP, PRED_TAKEN_SP, PRED_ADR_SP, PRED_RAS_SP
    );
endinterface

// File: rtl/branch_pred_unit.sv
// ---------------------------------------------------------------------------
// branch_pred_unit
//   Fetch-side branch predictor: fully associative BTB with 2-bit saturating
//   counters and a per-entry return flag, plus a circular return address
//   stack. Predictions are registered (one-cycle lookup latency). Updates
//   written in cycle N are seen by lookups issued in cycle N+1.
//
// Ports
//   clk      : clock
//   reset_n  : asynchronous, active-low reset
//   bp       : branch_pred_if.slave (lookup, update, flush, prediction)
//
// The ADR_W parameter must match the ADR_W of the connected interface.
// ---------------------------------------------------------------------------
module branch_pred_unit #(
    parameter int BTB_ENTRIES = 8,
    parameter int RAS_DEPTH   = 8,
    parameter int ADR_W       = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    branch_pred_if.slave   bp
);
    localparam int BI_W = $clog2(BTB_ENTRIES);
    localparam int RP_W = $clog2(RAS_DEPTH);
    localparam int RC_W = RP_W + 1;

    // BTB storage
    logic             btb_valid  [BTB_ENTRIES];
    logic [ADR_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [ADR_W-1:0] btb_target [BTB_ENTRIES];
    logic [1:0]       btb_ctr    [BTB_ENTRIES];
    logic             btb_ret    [BTB_ENTRIES];
    logic [BI_W-1:0]  rr_ptr;

    // RAS storage: ras_ptr always addresses the top-of-stack slot
    logic [ADR_W-1:0] ras_mem [RAS_DEPTH];
    logic [RP_W-1:0]  ras_ptr;
    logic [RC_W-1:0]  ras_cnt;
    logic [RP_W-1:0]  ras_ptr_inc;
    logic [RP_W-1:0]  ras_ptr_dec;

    // Prediction registers
    logic             pred_valid_q;
    logic             pred_taken_q;
    logic [ADR_W-1:0] pred_adr_q;
    logic             pred_ras_q;

    // Combinational lookup / update decode
    logic             lkp_hit;
    logic [BI_W-1:0]  lkp_idx;
    logic             pred_taken_d;
    logic [ADR_W-1:0] pred_adr_d;
    logic             pred_ras_d;

    logic             upd_hit;
    logic [BI_W-1:0]  upd_idx;
    logic             has_invalid;
    logic [BI_W-1:0]  inv_idx;
    logic [BI_W-1:0]  victim_idx;

    assign ras_ptr_inc = ras_ptr + RP_W'(1);
    assign ras_ptr_dec = ras_ptr - RP_W'(1);

    // Tag search. Scanning from the top index down lets the lowest matching
    // index be the last one written, so it wins on multiple matches.
    always_comb begin
        lkp_hit     = 1'b0;
        lkp_idx     = '0;
        upd_hit     = 1'b0;
        upd_idx     = '0;
        has_invalid = 1'b0;
        inv_idx     = '0;
        for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
            if (btb_valid[i] && btb_tag[i] == bp.LKP_ADR_SI) begin
                lkp_hit = 1'b1;
                lkp_idx = BI_W'(i);
            end
            if (btb_valid[i] && btb_tag[i] == bp.UPD_ADR_SI) begin
                upd_hit = 1'b1;
                upd_idx = BI_W'(i);
            end
            if (!btb_valid[i]) begin
                has_invalid = 1'b1;
                inv_idx     = BI_W'(i);
            end
        end
        victim_idx = has_invalid ? inv_idx : rr_ptr;
    end

    // Prediction for the presented PC, using pre-update state.
    always_comb begin
        pred_taken_d = 1'b0;
        pred_adr_d   = '0;
        pred_ras_d   = 1'b0;
        if (lkp_hit) begin
            if (!btb_ret[lkp_idx]) begin
                pred_taken_d = btb_ctr[lkp_idx][1];
                pred_adr_d   = btb_target[lkp_idx];
            end else if (ras_cnt != '0) begin
                pred_taken_d = 1'b1;
                pred_adr_d   = ras_mem[ras_ptr];
                pred_ras_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_adr_q   <= '0;
            pred_ras_q   <= 1'b0;
        end else if (bp.FLUSH_SI || !bp.LKP_VALID_SI) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_adr_q   <= '0;
            pred_ras_q   <= 1'b0;
        end else begin
            pred_valid_q <= 1'b1;
            pred_taken_q <= pred_taken_d;
            pred_adr_q   <= pred_adr_d;
            pred_ras_q   <= pred_ras_d;
        end
    end

    // BTB update / allocation. Flush wins over a same-cycle update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b00;
                btb_ret[i]    <= 1'b0;
            end
            rr_ptr <= '0;
        end else if (bp.FLUSH_SI) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
            end
            rr_ptr <= '0;
        end else if (bp.UPD_VALID_SI) begin
            if (upd_hit) begin
                if (bp.UPD_RET_SI) begin
                    btb_ctr[upd_idx] <= 2'b11;
                end else if (bp.UPD_TAKEN_SI) begin
                    if (btb_ctr[upd_idx] != 2'b11) btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                end else begin
                    if (btb_ctr[upd_idx] != 2'b00) btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                end
                if (bp.UPD_TAKEN_SI) btb_target[upd_idx] <= bp.UPD_TARGET_SI;
                btb_ret[upd_idx] <= bp.UPD_RET_SI;
            end else if (bp.UPD_TAKEN_SI || bp.UPD_RET_SI) begin
                btb_valid[victim_idx]  <= 1'b1;
                btb_tag[victim_idx]    <= bp.UPD_ADR_SI;
                btb_target[victim_idx] <= bp.UPD_TARGET_SI;
                btb_ctr[victim_idx]    <= bp.UPD_RET_SI ? 2'b11 : 2'b10;
                btb_ret[victim_idx]    <= bp.UPD_RET_SI;
                // Pointer only moves when it actually chose the victim.
                if (!has_invalid) rr_ptr <= rr_ptr + BI_W'(1);
            end
        end
    end

    // Return address stack. A full push wraps over the oldest slot; the count
    // simply stays saturated at RAS_DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem[i] <= '0;
            end
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (bp.FLUSH_SI) begin
            ras_cnt <= '0;
        end else if (bp.UPD_VALID_SI) begin
            if (bp.UPD_CALL_SI && bp.UPD_RET_SI) begin
                // Tail call style: replace the top in place.
                ras_mem[ras_ptr] <= bp.UPD_RET_ADR_SI;
                if (ras_cnt == '0) ras_cnt <= RC_W'(1);
            end else if (bp.UPD_CALL_SI) begin
                ras_ptr              <= ras_ptr_inc;
                ras_mem[ras_ptr_inc] <= bp.UPD_RET_ADR_SI;
                if (ras_cnt != RC_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + RC_W'(1);
            end else if (bp.UPD_RET_SI && ras_cnt != '0) begin
                ras_ptr <= ras_ptr_dec;
                ras_cnt <= ras_cnt - RC_W'(1);
            end
        end
    end

    assign bp.PRED_VALID_SP = pred_valid_q;
    assign bp.PRED_TAKEN_SP = pred_taken_q;
    assign bp.PRED_ADR_SP   = pred_adr_q;
    assign bp.PRED_RAS_SP   = pred_ras_q;
endmodule

// File: tb/tb_branch_pred_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_pred_unit
//   Directed scenarios followed by a random phase. Expected predictions come
//   from a behavioural model: BTB as plain arrays searched in index order and
//   the RAS as a bounded queue.
// ---------------------------------------------------------------------------
module tb_branch_pred_unit;
    localparam int N = 8;
    localparam int D = 8;
    localparam int W = 32;

    logic clk;
    logic reset_n;

    branch_pred_if #(.ADR_W(W)) bp ();

    branch_pred_unit #(
        .BTB_ENTRIES (N),
        .RAS_DEPTH   (D),
        .ADR_W       (W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bp      (bp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit         m_valid  [N];
    logic [W-1:0] m_tag    [N];
    logic [W-1:0] m_target [N];
    int         m_ctr    [N];
    bit         m_ret    [N];
    int         m_rr;
    logic [W-1:0] exp_q [$];   // RAS contents, oldest first

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        m_rr = 0;
        exp_q.delete();
    endtask

    task automatic model_predict(input logic [W-1:0] a, output bit t, output logic [W-1:0] adr,
                                 output bit r, output bit adr_known);
        int h;
        h = -1;
        t = 1'b0; adr = '0; r = 1'b0; adr_known = 1'b1;
        for (int i = 0; i < N; i++)
            if (h < 0 && m_valid[i] && m_tag[i] == a) h = i;
        if (h >= 0) begin
            if (!m_ret[h]) begin
                t   = (m_ctr[h] >= 2);
                adr = m_target[h];
            end else if (exp_q.size() > 0) begin
                t   = 1'b1;
                adr = exp_q[exp_q.size() - 1];
                r   = 1'b1;
            end else begin
                adr_known = 1'b0;   // target field unspecified in this case
            end
        end
    endtask

    task automatic model_update(input logic [W-1:0] ua, input logic [W-1:0] ut, input bit tk,
                                input bit cl, input bit rt, input logic [W-1:0] ra);
        int h;
        int v;
        h = -1;
        v = -1;
        for (int i = 0; i < N; i++)
            if (h < 0 && m_valid[i] && m_tag[i] == ua) h = i;
        if (h >= 0) begin
            if (rt) m_ctr[h] = 3;
            else if (tk) m_ctr[h] = (m_ctr[h] == 3) ? 3 : m_ctr[h] + 1;
            else m_ctr[h] = (m_ctr[h] == 0) ? 0 : m_ctr[h] - 1;
            if (tk) m_target[h] = ut;
            m_ret[h] = rt;
        end else if (tk || rt) begin
            for (int i = 0; i < N; i++)
                if (v < 0 && !m_valid[i]) v = i;
            if (v < 0) begin
                v = m_rr;
                m_rr = (m_rr + 1) % N;
            end
            m_valid[v]  = 1'b1;
            m_tag[v]    = ua;
            m_target[v] = ut;
            m_ctr[v]    = rt ? 3 : 2;
            m_ret[v]    = rt;
        end
        if (cl && rt) begin
            if (exp_q.size() == 0) exp_q.push_back(ra);
            else exp_q[exp_q.size() - 1] = ra;
        end else if (cl) begin
            exp_q.push_back(ra);
            if (exp_q.size() > D) void'(exp_q.pop_front());
        end else if (rt) begin
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end
    endtask

    // driver: one clock of stimulus, then check the registered prediction
    task automatic step(input bit lv, input logic [W-1:0] la, input bit uv, input logic [W-1:0] ua,
                        input logic [W-1:0] ut, input bit tk, input bit cl, input bit rt,
                        input logic [W-1:0] ra, input bit fl);
        bit e_v;
        bit e_t;
        bit e_r;
        bit a_known;
        logic [W-1:0] e_a;
        bp.LKP_VALID_SI   = lv;
        bp.LKP_ADR_SI     = la;
        bp.UPD_VALID_SI   = uv;
        bp.UPD_ADR_SI     = ua;
        bp.UPD_TARGET_SI  = ut;
        bp.UPD_TAKEN_SI   = tk;
        bp.UPD_CALL_SI    = cl;
        bp.UPD_RET_SI     = rt;
        bp.UPD_RET_ADR_SI = ra;
        bp.FLUSH_SI       = fl;
        model_predict(la, e_t, e_a, e_r, a_known);
        e_v = lv && !fl;
        if (!e_v) begin
            e_t = 1'b0; e_a = '0; e_r = 1'b0; a_known = 1'b1;
        end
        @(posedge clk);
        #1;
        if (fl) model_clear();
        else if (uv) model_update(ua, ut, tk, cl, rt, ra);
        chk("pred_valid", W'(bp.PRED_VALID_SP), W'(e_v));
        chk("pred_taken", W'(bp.PRED_TAKEN_SP), W'(e_t));
        chk("pred_ras", W'(bp.PRED_RAS_SP), W'(e_r));
        if (a_known) chk("pred_adr", bp.PRED_ADR_SP, e_a);
    endtask

    task automatic lkp(input logic [W-1:0] a);
        step(1'b1, a, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic upd(input logic [W-1:0] a, input logic [W-1:0] t, input bit tk,
                       input bit cl, input bit rt, input logic [W-1:0] ra);
        step(1'b0, '0, 1'b1, a, t, tk, cl, rt, ra, 1'b0);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, W'(bp.PRED_VALID_SP), '0);
        chk({tag, "_taken"}, W'(bp.PRED_TAKEN_SP), '0);
        chk({tag, "_ras"}, W'(bp.PRED_RAS_SP), '0);
        chk({tag, "_adr"}, bp.PRED_ADR_SP, '0);
    endtask

    initial begin
        logic [W-1:0] pool_a;
        logic [W-1:0] pool_u;
        reset_n           = 1'b0;
        bp.LKP_VALID_SI   = 1'b0;
        bp.LKP_ADR_SI     = '0;
        bp.UPD_VALID_SI   = 1'b0;
        bp.UPD_ADR_SI     = '0;
        bp.UPD_TARGET_SI  = '0;
        bp.UPD_TAKEN_SI   = 1'b0;
        bp.UPD_CALL_SI    = 1'b0;
        bp.UPD_RET_SI     = 1'b0;
        bp.UPD_RET_ADR_SI = '0;
        bp.FLUSH_SI       = 1'b0;
        for (int i = 0; i < N; i++) m_ctr[i] = 0;
        model_clear();
        #12;
        chk_outputs_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // first lookup misses
        lkp(32'h100);
        chk("first_lkp_valid", W'(bp.PRED_VALID_SP), W'(1));
        chk("first_lkp_adr", bp.PRED_ADR_SP, '0);

        // counter training
        upd(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, '0);
        lkp(32'h100);
        chk("alloc_taken", W'(bp.PRED_TAKEN_SP), W'(1));
        chk("alloc_adr", bp.PRED_ADR_SP, 32'h200);
        upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        lkp(32'h100);
        chk("ctr00_taken", W'(bp.PRED_TAKEN_SP), W'(0));
        for (int i = 0; i < 3; i++) upd(32'h100, 32'h240, 1'b1, 1'b0, 1'b0, '0);
        lkp(32'h100);
        chk("ctr11_taken", W'(bp.PRED_TAKEN_SP), W'(1));
        chk("ctr11_adr", bp.PRED_ADR_SP, 32'h240);
        upd(32'h100, 32'h240, 1'b1, 1'b0, 1'b0, '0);
        upd(32'h100, 32'h0, 1'b0, 1'b0, 1'b0, '0);
        lkp(32'h100);
        chk("ctr_saturate", W'(bp.PRED_TAKEN_SP), W'(1));

        // flush beats a same-cycle update
        step(1'b0, '0, 1'b1, 32'h700, 32'h7000, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        lkp(32'h100);
        chk("flush_old_miss", W'(bp.PRED_TAKEN_SP), W'(0));
        lkp(32'h700);
        chk("flush_upd_dropped", W'(bp.PRED_TAKEN_SP), W'(0));

        // allocation and round-robin eviction
        for (int i = 0; i < 9; i++) upd(W'(i * 4), W'(32'h8000 + i * 4), 1'b1, 1'b0, 1'b0, '0);
        lkp(32'h0);
        chk("evict0_miss", W'(bp.PRED_TAKEN_SP), W'(0));
        lkp(32'h20);
        chk("ninth_hit_adr", bp.PRED_ADR_SP, 32'h8020);
        upd(32'h24, 32'h8024, 1'b1, 1'b0, 1'b0, '0);
        lkp(32'h4);
        chk("evict1_miss", W'(bp.PRED_TAKEN_SP), W'(0));
        lkp(32'h8);
        chk("entry2_hit_adr", bp.PRED_ADR_SP, 32'h8008);

        // RAS push/pop via a return entry
        upd(32'h50, '0, 1'b0, 1'b1, 1'b0, 32'h104);
        upd(32'h60, '0, 1'b0, 1'b1, 1'b0, 32'h208);
        upd(32'h300, '0, 1'b0, 1'b0, 1'b1, '0);
        lkp(32'h300);
        chk("ret_taken", W'(bp.PRED_TAKEN_SP), W'(1));
        chk("ret_ras", W'(bp.PRED_RAS_SP), W'(1));
        chk("ret_adr", bp.PRED_ADR_SP, 32'h104);

        // overflow: nine pushes on top of one live entry
        for (int i = 0; i < 9; i++) upd(32'h50, '0, 1'b0, 1'b1, 1'b0, W'(32'h1000 + i * 16));
        for (int k = 0; k < 9; k++) begin
            lkp(32'h300);
            if (k == 0) chk("ras_top_newest", bp.PRED_ADR_SP, 32'h1080);
            if (k == 7) chk("ras_last_kept", bp.PRED_ADR_SP, 32'h1010);
            if (k == 8) chk("ras_empty_taken", W'(bp.PRED_TAKEN_SP), W'(0));
            upd(32'h300, '0, 1'b0, 1'b0, 1'b1, '0);
        end
        upd(32'h300, '0, 1'b0, 1'b0, 1'b1, '0);
        upd(32'h50, '0, 1'b0, 1'b1, 1'b0, 32'h2220);
        lkp(32'h300);
        chk("pop_empty_push_adr", bp.PRED_ADR_SP, 32'h2220);
        upd(32'h300, '0, 1'b0, 1'b0, 1'b1, '0);
        lkp(32'h300);
        chk("pop_to_empty_taken", W'(bp.PRED_TAKEN_SP), W'(0));

        // call and return in the same update
        upd(32'h300, '0, 1'b0, 1'b1, 1'b1, 32'h4440);
        lkp(32'h300);
        chk("callret_empty_adr", bp.PRED_ADR_SP, 32'h4440);
        upd(32'h300, '0, 1'b0, 1'b1, 1'b1, 32'h5550);
        lkp(32'h300);
        chk("callret_replace_adr", bp.PRED_ADR_SP, 32'h5550);
        upd(32'h300, '0, 1'b0, 1'b0, 1'b1, '0);
        lkp(32'h300);
        chk("callret_pop_taken", W'(bp.PRED_TAKEN_SP), W'(0));

        // same-cycle update and lookup
        step(1'b1, 32'h500, 1'b1, 32'h500, 32'h900, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        chk("same_cycle_miss", W'(bp.PRED_TAKEN_SP), W'(0));
        lkp(32'h500);
        chk("next_cycle_hit", bp.PRED_ADR_SP, 32'h900);

        // asynchronous reset mid-stream
        #2;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        model_clear();
        #2;
        reset_n = 1'b1;
        lkp(32'h500);
        chk("post_reset_miss", W'(bp.PRED_TAKEN_SP), W'(0));

        // random phase against the model
        for (int n = 0; n < 400; n++) begin
            pool_a = W'($urandom_range(0, 15) * 4);
            pool_u = W'($urandom_range(0, 15) * 4);
            step(1'($urandom_range(0, 1)), pool_a, 1'($urandom_range(0, 1)), pool_u,
                 $urandom & 32'hffff_fffc, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 $urandom & 32'hffff_fffc, ($urandom_range(0, 39) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_pred_unit.md
# branch_pred_unit

Parametrised fetch-side branch predictor: a fully associative branch target buffer (BTB) with 2-bit saturating counters, plus a circular return address stack (RAS). It sits beside the instruction fetch stage. Fetch presents the PC each cycle and receives a registered prediction one cycle later. Decode/execute report resolved branches, calls and returns back to it through the update port.

## Interface
Parameters:
- BTB_ENTRIES, 8: number of BTB entries; power of two, ≥2
- RAS_DEPTH, 8: number of RAS slots; power of two, ≥2
- ADR_W, 32: address width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- LKP_VALID_SI  in  1  lookup request
- LKP_ADR_SI  in  ADR_W  fetch PC to predict
- PRED_VALID_SP  out  1  prediction valid, one cycle after LKP_VALID_SI
- PRED_TAKEN_SP  out  1  predict redirect
- PRED_ADR_SP  out  ADR_W  predicted target
- PRED_RAS_SP  out  1  target came from RAS
- UPD_VALID_SI  in  1  resolved control-flow instruction
- UPD_ADR_SI  in  ADR_W  address of resolved instruction
- UPD_TARGET_SI  in  ADR_W  actual target (branch/jump)
- UPD_TAKEN_SI  in  1  actual outcome
- UPD_CALL_SI  in  1  instruction is a call; push UPD_RET_ADR_SI
- UPD_RET_SI  in  1  instruction is a return
- UPD_RET_ADR_SI  in  ADR_W  return address to push (call PC + 4)
- FLUSH_SI  in  1  invalidate all predictor state

## Operation
- BTB entry: valid, tag (full ADR_W address), target, 2-bit counter, ret flag. Counter 00 = strong not-taken, 01 = weak not-taken, 10 = weak taken, 11 = strong taken. Predict taken iff counter[1].
- Lookup: compare LKP_ADR_SI against all valid tags. If several match, lowest index wins.
  - Hit, ret=0: PRED_TAKEN = counter[1], PRED_ADR = target, PRED_RAS = 0.
  - Hit, ret=1, RAS non-empty: PRED_TAKEN = 1, PRED_ADR = RAS top, PRED_RAS = 1.
  - Hit, ret=1, RAS empty: PRED_TAKEN = 0.
  - Miss: PRED_TAKEN = 0, PRED_ADR = 0, PRED_RAS = 0.
- Update hit (UPD_VALID_SI, tag match):
  - Taken: counter saturating +1 and target ← UPD_TARGET_SI.
  - Not taken: counter saturating −1.
  - ret flag ← UPD_RET_SI. If UPD_RET_SI is set, the counter is forced to 11.
- Update miss, allocate only if UPD_TAKEN_SI or UPD_RET_SI:
  - Victim is the lowest-index invalid entry; if none, the round-robin pointer entry.
  - Round-robin pointer increments (mod BTB_ENTRIES) only when it supplies the victim.
  - New entry: valid = 1, counter = 10 (11 if ret), target = UPD_TARGET_SI.
  - A not-taken, non-return miss leaves the BTB unchanged.
- RAS: top pointer plus count in 0..RAS_DEPTH.
  - Push (UPD_VALID_SI & UPD_CALL_SI): pointer+1 mod RAS_DEPTH, write UPD_RET_ADR_SI, count saturates at RAS_DEPTH. When full, the oldest entry is overwritten.
  - Pop (UPD_VALID_SI & UPD_RET_SI): pointer−1 mod RAS_DEPTH, count−1. Pop on empty is ignored.
  - Call and ret together: top entry replaced by UPD_RET_ADR_SI, pointer unchanged. Count stays the same, except that if count = 0 it becomes 1.
- FLUSH_SI: clears all BTB valid bits, RAS count, round-robin pointer, and PRED_VALID_SP on the next edge. Flush has priority over a same-cycle update, and that update is dropped.

## Timing
- Reset (async assert, sync release): all valid bits 0, counters 00, round-robin pointer 0, RAS pointer/count 0.
- Outputs at reset: PRED_VALID_SP = 0, PRED_TAKEN_SP = 0, PRED_RAS_SP = 0, PRED_ADR_SP = 0.
- Lookup latency is 1 cycle; prediction outputs are registered. PRED_VALID_SP is LKP_VALID_SI delayed one cycle. When PRED_VALID_SP = 0, the other outputs are 0.
- An update in cycle N is visible to lookups issued in cycle N+1. A lookup in cycle N sees pre-update state, including the RAS top.
- One update per cycle; no back-pressure; the update port is always accepted.
- Reset asserted mid-operation clears all state immediately, regardless of clock.
- Widths: all addresses ADR_W. Pointers are $clog2 of their depth. The RAS count is $clog2(RAS_DEPTH)+1 bits.

## Test plan
- Reset, then lookup 0x100 → next cycle PRED_VALID = 1, PRED_TAKEN = 0, PRED_ADR = 0.
- Update 0x100 taken → 0x200, then lookup 0x100 → TAKEN = 1, ADR = 0x200. Follow with two not-taken updates → counter 00, lookup gives TAKEN = 0. Follow with three taken updates → counter 11 (saturated).
- Allocate 9 taken branches 0x0..0x20 step 4 with BTB_ENTRIES = 8 → the ninth evicts entry 0, so lookup 0x0 misses and 0x20 hits. A tenth allocation evicts entry 1.
- Call pushes 0x104, 0x208, then a ret at 0x300 is updated → lookup 0x300 gives TAKEN = 1, RAS = 1, ADR = 0x104.
- Push 9 addresses into RAS_DEPTH = 8 → the oldest is lost. Nine pops with a ret lookup between each → the ninth lookup gives TAKEN = 0. A pop on empty leaves count at 0.
- Same-cycle checks:
  - FLUSH_SI with an update → all subsequent lookups miss.
  - Update and lookup of the same address in one cycle → the lookup misses and the next lookup hits.
  - reset_n pulsed mid-stream → all outputs 0 immediately.
